// File: rtl/unidad_writeback.sv
// Write-back stage: arbitrates ALU results and buffered load responses
// onto the single register-file write port; tracks outstanding loads.
module unidad_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_issue,
    input  logic [4:0]      ld_issue_rd,
    output logic            ld_issue_rdy,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            stall,
    output logic [4:0]      writeReg,
    output logic [XLEN-1:0] writeData,
    output logic            RegWrite,
    output logic [31:0]     pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      fifoRd   [DEPTH];
    logic [XLEN-1:0] fifoData [DEPTH];
    logic [PW-1:0]   wrPtr;
    logic [PW-1:0]   rdPtr;
    logic [CW-1:0]   count;
    logic            outIsLoad;

    logic        aluWins;
    logic        pushEn;
    logic        popEn;
    logic        setEn;
    logic        hz1;
    logic        hz2;
    logic [31:0] pendingNext;

    assign ld_ready     = count < CW'(DEPTH);
    assign ld_issue_rdy = !pending[ld_issue_rd] || (ld_issue_rd == 5'd0);

    // x0 responses complete the handshake but never occupy an entry
    assign pushEn  = ld_valid && ld_ready && (ld_rd != 5'd0);
    assign aluWins = alu_valid && (alu_rd != 5'd0);
    assign popEn   = !aluWins && (count != '0);
    assign setEn   = ld_issue && ld_issue_rdy && (ld_issue_rd != 5'd0);

    // In-flight write term covers the gap before the register file commits
    assign hz1 = (rs1 != 5'd0) &&
                 (pending[rs1] || (RegWrite && writeReg == rs1));
    assign hz2 = (rs2 != 5'd0) &&
                 (pending[rs2] || (RegWrite && writeReg == rs2));
    assign stall = hz1 || hz2;

    always_comb begin
        pendingNext = pending;
        if (RegWrite && outIsLoad)
            pendingNext[writeReg] = 1'b0;
        if (setEn)
            pendingNext[ld_issue_rd] = 1'b1;
        pendingNext[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (pushEn) begin
            fifoRd[wrPtr]   <= ld_rd;
            fifoData[wrPtr] <= ld_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            outIsLoad <= 1'b0;
            RegWrite  <= 1'b0;
            writeReg  <= 5'd0;
            writeData <= '0;
            pending   <= '0;
        end else begin
            pending <= pendingNext;
            if (pushEn)
                wrPtr <= wrPtr + 1'b1;
            if (popEn)
                rdPtr <= rdPtr + 1'b1;
            if (pushEn && !popEn)
                count <= count + 1'b1;
            else if (popEn && !pushEn)
                count <= count - 1'b1;
            unique case (1'b1)
                aluWins: begin
                    RegWrite  <= 1'b1;
                    writeReg  <= alu_rd;
                    writeData <= alu_data;
                    outIsLoad <= 1'b0;
                end
                popEn: begin
                    RegWrite  <= 1'b1;
                    writeReg  <= fifoRd[rdPtr];
                    writeData <= fifoData[rdPtr];
                    outIsLoad <= 1'b1;
                end
                default: begin
                    RegWrite  <= 1'b0;
                    outIsLoad <= 1'b0;
                end
            endcase
        end
    end

endmodule
